// File: rtl/alu_seq_pkg.sv
// Shared mode and FSM state encodings for the sequential A/B ALU.
// Latency: none (definitions only); backpressure: not applicable.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_RSUB = 2'd2,
    MODE_ACC  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_GET_A = 2'd0,
    ST_GET_B = 2'd1,
    ST_READY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_a_b_seq_n_bits_key_pulse.sv
// Raw active-low key -> 2-FF synchroniser -> one-cycle pulse on press only.
// Latency: pulse is high during the 2nd clk after the key falls; no backpressure.
module key_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // All flops reset to 1 so a released key never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_prev & ~r_sync2;

endmodule

// File: rtl/alu_a_b_seq_n_bits.sv
// Sequential A/B ALU: load key captures A then B, exec key computes and holds result.
// Latency: result registered 1 clk after the exec pulse; keys are never backpressured.
module alu_a_b_seq_n_bits
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_n,
  input  logic             exec_n,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             valid,
  output logic [1:0]       state
);

  logic             w_load_pls;
  logic             w_exec_pls;
  mode_t            w_mode;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic             w_do_exec;

  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_valid;
  state_t           r_state;

  key_pulse u_load_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (load_n),
    .o_pulse (w_load_pls)
  );

  key_pulse u_exec_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (exec_n),
    .o_pulse (w_exec_pls)
  );

  assign w_mode = mode_t'(mode);

  // Subtract modes invert one adder input and inject a carry, so carry=1 means no borrow.
  always_comb begin
    w_add_a = r_op_a;
    w_add_b = r_op_b;
    w_cin   = 1'b0;
    case (w_mode)
      MODE_SUB: begin
        w_add_b = ~r_op_b;
        w_cin   = 1'b1;
      end
      MODE_RSUB: begin
        w_add_a = ~r_op_a;
        w_cin   = 1'b1;
      end
      default: begin
        w_add_a = r_op_a;
        w_add_b = r_op_b;
      end
    endcase
  end

  assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != w_add_a[WIDTH-1]);

  // A simultaneous load pulse always suppresses exec.
  assign w_do_exec = w_exec_pls && !w_load_pls &&
                     ((r_state == ST_READY) || (r_state == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_state    <= ST_GET_A;
    end else if (w_load_pls) begin
      case (r_state)
        ST_GET_A: begin
          r_op_a  <= data_in;
          r_state <= ST_GET_B;
        end
        ST_GET_B: begin
          r_op_b  <= data_in;
          r_state <= ST_READY;
        end
        ST_DONE: begin
          r_op_a  <= data_in;
          r_valid <= 1'b0;
          r_state <= ST_GET_B;
        end
        default: r_state <= r_state;
      endcase
    end else if (w_do_exec) begin
      r_result   <= w_sum[WIDTH-1:0];
      r_carry    <= w_sum[WIDTH];
      r_overflow <= w_ovf;
      r_valid    <= 1'b1;
      r_state    <= ST_DONE;
      if (w_mode == MODE_ACC) begin
        r_op_a <= w_sum[WIDTH-1:0];
      end
    end
  end

  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign valid    = r_valid;
  assign state    = r_state;

endmodule

// File: tb/tb_alu_a_b_seq_n_bits.sv
// Directed bench for the sequential ALU at WIDTH=8 and WIDTH=16.
// Exec results are queued from a reference model and compared once the DUT updates.
module tb_alu_a_b_seq_n_bits;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] data16;
  logic [7:0]  data8;
  logic        load_n;
  logic        exec_n;
  logic [1:0]  mode;

  logic [7:0]  op_a8, op_b8, result8;
  logic        carry8, overflow8, valid8;
  logic [1:0]  state8;
  logic [15:0] op_a16, op_b16, result16;
  logic        carry16, overflow16, valid16;
  logic [1:0]  state16;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];

  logic [7:0] m_a, m_b, m_res;
  logic       m_c, m_v, m_valid;
  logic [1:0] m_state;

  assign data8 = data16[7:0];

  alu_a_b_seq_n_bits #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(data8), .load_n(load_n), .exec_n(exec_n),
    .mode(mode), .op_a(op_a8), .op_b(op_b8), .result(result8), .carry(carry8),
    .overflow(overflow8), .valid(valid8), .state(state8)
  );

  alu_a_b_seq_n_bits #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .data_in(data16), .load_n(load_n), .exec_n(exec_n),
    .mode(mode), .op_a(op_a16), .op_b(op_b16), .result(result16), .carry(carry16),
    .overflow(overflow16), .valid(valid16), .state(state16)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference arithmetic: true unsigned/signed values, then range tests.
  function automatic exp_t model_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] md);
    exp_t   e;
    longint lim, ua, ub, sa, sb, ut, st;
    lim = longint'(1) << w;
    ua  = longint'(a) & (lim - 1);
    ub  = longint'(b) & (lim - 1);
    sa  = (ua >= lim / 2) ? ua - lim : ua;
    sb  = (ub >= lim / 2) ? ub - lim : ub;
    case (md)
      2'b01:   begin ut = ua - ub; st = sa - sb; e.c = (ua >= ub); end
      2'b10:   begin ut = ub - ua; st = sb - sa; e.c = (ub >= ua); end
      default: begin ut = ua + ub; st = sa + sb; e.c = (ut >= lim); end
    endcase
    e.res = 32'(ut & (lim - 1));
    e.v   = (st >= lim / 2) || (st < -(lim / 2));
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".op_a"},     32'(op_a8),     32'(m_a));
    check({tag, ".op_b"},     32'(op_b8),     32'(m_b));
    check({tag, ".result"},   32'(result8),   32'(m_res));
    check({tag, ".carry"},    32'(carry8),    32'(m_c));
    check({tag, ".overflow"}, 32'(overflow8), 32'(m_v));
    check({tag, ".valid"},    32'(valid8),    32'(m_valid));
    check({tag, ".state"},    32'(state8),    32'(m_state));
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_res = '0;
    m_c = 1'b0; m_v = 1'b0; m_valid = 1'b0; m_state = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_load(input logic [7:0] d);
    case (m_state)
      2'd0: begin m_a = d; m_state = 2'd1; end
      2'd1: begin m_b = d; m_state = 2'd2; end
      2'd3: begin m_a = d; m_valid = 1'b0; m_state = 2'd1; end
      default: m_state = m_state;
    endcase
  endtask

  task automatic do_load(input logic [15:0] d, input string tag);
    @(negedge clk);
    data16 = d;
    load_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_load(d[7:0]);
    check_all(tag);
    @(negedge clk);
    load_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic do_exec(input logic [1:0] md, input string tag);
    exp_t e;
    @(negedge clk);
    mode   = md;
    exec_n = 1'b0;
    if (m_state >= 2'd2) sb_q.push_back(model_op(8, 32'(m_a), 32'(m_b), md));
    repeat (2) @(posedge clk);
    #1;
    check({tag, ".early_result"}, 32'(result8), 32'(m_res));
    check({tag, ".early_valid"},  32'(valid8),  32'(m_valid));
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      m_res = e.res[7:0]; m_c = e.c; m_v = e.v;
      m_valid = 1'b1; m_state = 2'd3;
      if (md == 2'b11) m_a = e.res[7:0];
    end
    check_all(tag);
    @(negedge clk);
    exec_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    exp_t e16;
    rst_n  = 1'b0;
    data16 = '0;
    load_n = 1'b1;
    exec_n = 1'b1;
    mode   = 2'b00;
    model_reset();
    #25;
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of GET_B discards the captured A.
    do_load(16'h0012, "load_a12");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    do_load(16'h0034, "load_fresh");

    do_reset();
    do_load(16'h00F0, "add_a");
    do_load(16'h0020, "add_b");
    do_exec(2'b00, "add");

    @(negedge clk);
    mode = 2'b01;
    repeat (5) @(posedge clk);
    #1;
    check_all("mode_no_exec");

    do_load(16'h0050, "done_load");
    do_exec(2'b01, "exec_getb");
    do_load(16'h0070, "sub_b");
    do_exec(2'b01, "sub");
    do_exec(2'b10, "rsub");

    do_load(16'h0080, "ovf_a");
    do_load(16'h0001, "ovf_b");
    do_exec(2'b01, "sub_ovf");

    // Held key: one capture of A, later bus changes must not reach op_b.
    @(negedge clk);
    data16 = 16'h0005;
    load_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_load(8'h05);
    check_all("hold_first");
    @(negedge clk);
    data16 = 16'h0099;
    repeat (1000) @(posedge clk);
    #1;
    check_all("hold_1000");
    @(negedge clk);
    load_n = 1'b1;
    repeat (3) @(posedge clk);

    do_load(16'h0003, "acc_b");
    do_exec(2'b11, "acc1");
    do_exec(2'b11, "acc2");
    do_exec(2'b11, "acc3");

    // Load and exec pressed together in DONE: load wins.
    @(negedge clk);
    data16 = 16'h0044;
    load_n = 1'b0;
    exec_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_load(8'h44);
    check_all("load_exec_same");
    @(negedge clk);
    load_n = 1'b1;
    exec_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_all("after_same");

    do_reset();
    do_load(16'hFFFF, "w16_a");
    do_load(16'h0001, "w16_b");
    do_exec(2'b00, "w16_add");
    e16 = model_op(16, 32'h0000FFFF, 32'h00000001, 2'b00);
    check("w16.result",   32'(result16),   e16.res);
    check("w16.carry",    32'(carry16),    32'(e16.c));
    check("w16.overflow", 32'(overflow16), 32'(e16.v));
    check("w16.valid",    32'(valid16),    32'd1);
    check("w16.op_a",     32'(op_a16),     32'h0000FFFF);
    check("w16.state",    32'(state16),    32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_a_b_seq_n_bits.md
Name: alu_a_b_seq_n_bits

Overview:
Parametrised sequential successor to the 8-bit A/B adder board block.
- Captures operands A and B from one shared data bus using two debounced-free push-button strobes (load, exec).
- Executes add, subtract, reverse-subtract or accumulate, registers the result with carry/overflow flags, and holds it for display.
- Sits between board switches/keys and the hex display decoders; the board top splits A, B and the result into nibbles.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 4..32).

Ports:
clk  input  1  system clock (board 50 MHz).
rst_n  input  1  asynchronous active-low reset.
data_in  input  WIDTH  operand bus from switches.
load_n  input  1  raw active-low load key, asynchronous to clk.
exec_n  input  1  raw active-low execute key, asynchronous to clk.
mode  input  2  operation select, sampled on the exec pulse.
op_a  output  WIDTH  captured operand A.
op_b  output  WIDTH  captured operand B.
result  output  WIDTH  registered result.
carry  output  1  unsigned carry out; for subtract modes, 1 = no borrow.
overflow  output  1  signed two's-complement overflow.
valid  output  1  result is current for the held A, B and mode.
state  output  2  FSM state, for LED debug.

Behaviour:
Reset
- Async assert on rst_n=0.
- op_a, op_b and result reset to 0; carry, overflow and valid reset to 0; state resets to GET_A.
- Synchroniser flops reset to 1 (key released).
- Reset mid-operation discards everything; no partial capture survives.

Key conditioning
- Each key goes through a 2-FF synchroniser followed by a previous-value register.
- A pulse is one clk cycle wide, on the falling edge only: previous=1, current=0.
- A held key produces exactly one pulse; release produces none.
- Key fall to pulse latency is 3 clk cycles worst case.

Modes
- 00 ADD: A+B.
- 01 SUB: A-B, computed as A+~B+1.
- 10 RSUB: B-A.
- 11 ACC: A+B, and A is also updated to the sum.

Arithmetic and width rules
- Sum is WIDTH+1 bits; result = low WIDTH bits; carry = bit WIDTH.
- Overflow is set when both adder inputs (after inversion for subtract) have the same sign and the result sign differs.
- Wrap-around is modulo 2^WIDTH; no saturation.

FSM states and transitions (encoding 0..3)
- GET_A: load pulse -> op_a <= data_in, go to GET_B.
- GET_B: load pulse -> op_b <= data_in, go to READY.
- READY: exec pulse -> compute per the sampled mode, register result/carry/overflow, valid <= 1, go to DONE. Result appears on the cycle after the pulse (1-cycle latency).
- DONE, exec pulse:
  - Recompute with current op_a, op_b and mode; stay in DONE.
  - In ACC, op_a <= result of that exec, so repeated exec adds op_b each time (running total).
- DONE, load pulse: op_a <= data_in, valid <= 0, go to GET_B (op_b kept until overwritten).

Boundary rules
- exec pulse in GET_A or GET_B: ignored; no output change.
- Load and exec pulse in the same cycle: load wins, exec dropped.
- A mode change without an exec does not alter result or flags.
- valid stays 1 through a non-ACC re-exec.

Decomposition:
- Package alu_seq_pkg: mode constants (MODE_ADD, MODE_SUB, MODE_RSUB, MODE_ACC) and state constants (ST_GET_A, ST_GET_B, ST_READY, ST_DONE).
- Sub-module key_pulse (synchroniser + falling-edge detector, reset-to-1), instantiated twice.
- Arithmetic stays inline.

Test Plan:
- Reset: assert rst_n=0 mid-GET_B after A=0x12 -> all outputs 0, state=GET_A; after release, first load captures A afresh.
- ADD, WIDTH=8: load 0xF0, load 0x20, mode=00, exec -> result=0x10, carry=1, overflow=0, valid=1 one cycle after the pulse.
- SUB/RSUB, WIDTH=8:
  - A=0x50, B=0x70, mode=01 -> result=0xE0, carry=0, overflow=0.
  - mode=10, exec again -> result=0x20, carry=1.
  - A=0x80, B=0x01, mode=01 -> result=0x7F, overflow=1.
- ACC: A=0x05, B=0x03, mode=11, exec x3 -> result 0x08, 0x0B, 0x0E; op_a tracks result.
- Key hygiene:
  - Hold load_n low for 1000 cycles -> exactly one capture.
  - Exec in GET_B -> no change.
  - Load and exec falling in the same cycle in DONE -> op_a captured, valid=0, state=GET_B.
- WIDTH=16 rerun of ADD: 0xFFFF+0x0001 -> result=0x0000, carry=1, overflow=0.
